// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment codes are active-low: bit 0 = a ... bit 6 = g, bit 7 = dp.
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        SC_OFF  = 2'd0,
        SC_GAP  = 2'd1,
        SC_SHOW = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_scan_drv_if.sv
// Display-data bundle between the panel state logic (master) and the scan driver (slave).
interface seg_scan_drv_if;
    import seg_pkg::*;

    logic                      en;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic                      lz_en;
    logic [1:0]                sel_0;
    logic [NUM_DIGITS-1:0]     sel;
    logic [7:0]                seg;

    modport master (
        output en, digits, dp_mask, blink_mask, lz_en,
        input  sel_0, sel, seg
    );

    modport slave (
        input  en, digits, dp_mask, blink_mask, lz_en,
        output sel_0, sel, seg
    );

endinterface

// File: rtl/seg_decode.sv
// BCD nibble to active-low a..g pattern; A renders as a dash, B..F stay dark.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK[6:0];
        case (i_nib)
            4'h0: o_seg = SEG_0[6:0];
            4'h1: o_seg = SEG_1[6:0];
            4'h2: o_seg = SEG_2[6:0];
            4'h3: o_seg = SEG_3[6:0];
            4'h4: o_seg = SEG_4[6:0];
            4'h5: o_seg = SEG_5[6:0];
            4'h6: o_seg = SEG_6[6:0];
            4'h7: o_seg = SEG_7[6:0];
            4'h8: o_seg = SEG_8[6:0];
            4'h9: o_seg = SEG_9[6:0];
            4'hA: o_seg = SEG_DASH[6:0];
            default: o_seg = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/seg_scan_drv.sv
// Six-digit multiplexed driver for the common-anode segment bank.
// state | meaning:  OFF = display dark, counters idle | GAP = all digits off at slot start | SHOW = current digit lit
module seg_scan_drv
    import seg_pkg::*;
#(
    parameter int SCAN_CNT_MAX = 49_999,
    parameter int GAP_CYC      = 500,
    parameter int BLINK_SLOTS  = 500
) (
    input  logic          clk,
    input  logic          rstn,
    seg_scan_drv_if.slave bus
);

    localparam int CNT_W = $clog2(SCAN_CNT_MAX + 1);
    localparam int BLK_W = $clog2(BLINK_SLOTS);

    localparam logic [1:0] ST_OFF  = SC_OFF;
    localparam logic [1:0] ST_GAP  = SC_GAP;
    localparam logic [1:0] ST_SHOW = SC_SHOW;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CNT_MAX);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_SLOTS - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [1:0]                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [2:0]                r_idx;
    logic [BLK_W-1:0]          r_blk_cnt;
    logic                      r_phase;
    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [NUM_DIGITS-1:0]     r_dp;
    logic [NUM_DIGITS-1:0]     r_blink;
    logic                      r_lz;
    logic [NUM_DIGITS-1:0]     r_sel;
    logic [7:0]                r_seg;

    logic                      w_slot_end;
    logic                      w_snap;
    logic [NUM_DIGITS-1:0]     w_lz_mask;
    logic                      w_lead;
    logic [3:0]                w_nib;
    logic                      w_dp_on;
    logic                      w_blank;
    logic [6:0]                w_dec;

    assign w_slot_end = (r_state == ST_SHOW) && (r_cnt == CNT_LAST);
    assign w_snap     = (r_state == ST_OFF) || (w_slot_end && (r_idx == IDX_LAST));

    // Zeros are suppressed from the top digit down until the first non-zero nibble; digit 0 always shows.
    always_comb begin
        w_lz_mask = '0;
        w_lead    = r_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lead       = w_lead && (r_digits[4*i +: 4] == 4'h0);
            w_lz_mask[i] = w_lead;
        end
    end

    always_comb begin
        w_nib   = 4'h0;
        w_dp_on = 1'b0;
        w_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == 3'(i)) begin
                w_nib   = r_digits[4*i +: 4];
                w_dp_on = r_dp[i];
                w_blank = (r_blink[i] && !r_phase) || w_lz_mask[i];
            end
        end
    end

    seg_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_OFF;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_blk_cnt <= '0;
            r_phase   <= 1'b1;
            r_digits  <= '0;
            r_dp      <= '0;
            r_blink   <= '0;
            r_lz      <= 1'b0;
            r_sel     <= '1;
            r_seg     <= SEG_BLANK;
        end else if (!bus.en) begin
            r_state   <= ST_OFF;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_blk_cnt <= '0;
            r_phase   <= 1'b1;
            r_sel     <= '1;
            r_seg     <= SEG_BLANK;
        end else begin
            r_sel <= '1;
            r_seg <= SEG_BLANK;
            if (r_state == ST_SHOW) begin
                r_sel <= ~(NUM_DIGITS'(1) << r_idx);
                r_seg <= w_blank ? SEG_BLANK : {~w_dp_on, w_dec};
            end

            case (r_state)
                ST_OFF: begin
                    r_state <= ST_GAP;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                end
                ST_GAP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == GAP_LAST) r_state <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (w_slot_end) begin
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                        r_idx   <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
                        if (r_blk_cnt == BLK_LAST) begin
                            r_blk_cnt <= '0;
                            r_phase   <= ~r_phase;
                        end else begin
                            r_blk_cnt <= r_blk_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_OFF;
            endcase

            // A whole frame is drawn from one snapshot, taken at scan start and at each 5->0 wrap.
            if (w_snap) begin
                r_digits <= bus.digits;
                r_dp     <= bus.dp_mask;
                r_blink  <= bus.blink_mask;
                r_lz     <= bus.lz_en;
            end
        end
    end

    assign bus.sel   = r_sel;
    assign bus.seg   = r_seg;
    assign bus.sel_0 = 2'b11;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv with a 10-clock slot (2 gap + 8 show) and 12-slot blink half-period.
module tb_seg_scan_drv;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;

    seg_scan_drv_if bus ();

    seg_scan_drv #(
        .SCAN_CNT_MAX (9),
        .GAP_CYC      (2),
        .BLINK_SLOTS  (12)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [23:0]      digits;
        logic [5:0]       dp;
        logic [5:0]       blink;
        logic             lz;
        logic [5:0][7:0]  exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [5:0] es, input logic [7:0] eg);
        n_checks++;
        if (bus.sel !== es || bus.seg !== eg || bus.sel_0 !== 2'b11) begin
            n_fail++;
            $display("FAIL %s t=%0t got sel=%h seg=%h sel_0=%b want sel=%h seg=%h sel_0=11",
                     nm, $time, bus.sel, bus.seg, bus.sel_0, es, eg);
        end
    endtask

    task automatic run_slot(input string nm, input int idx, input logic [7:0] eg, input int ncyc);
        logic [5:0] es;
        es = ~(6'b000001 << idx);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c < 2) chk(nm, 6'h3F, 8'hFF);
            else       chk(nm, es, eg);
        end
    endtask

    task automatic run_frame(input string nm, input logic [5:0][7:0] exp);
        for (int i = 0; i < 6; i++) run_slot(nm, i, exp[i], 10);
    endtask

    task automatic rearm(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl, input logic lz);
        bus.en         = 1'b0;
        bus.digits     = d;
        bus.dp_mask    = dp;
        bus.blink_mask = bl;
        bus.lz_en      = lz;
        @(negedge clk);
        chk("en_off", 6'h3F, 8'hFF);
        bus.en = 1'b1;
        @(negedge clk);
        chk("en_start", 6'h3F, 8'hFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t bench did not complete", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"plain",    24'h123456, 6'b000000, 6'b0, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}};
        vecs[1] = '{"lz_50",    24'h000050, 6'b000000, 6'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h92, 8'hC0}};
        vecs[2] = '{"lz_zero",  24'h000000, 6'b000000, 6'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{"dash_dp",  24'h00BA00, 6'b000100, 6'b0, 1'b0, {8'hC0, 8'hC0, 8'hFF, 8'h3F, 8'hC0, 8'hC0}};
        vecs[4] = '{"lz_nonbcd",24'h0B0010, 6'b000000, 6'b0, 1'b1, {8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hF9, 8'hC0}};
        vecs[5] = '{"lz_dp",    24'h000007, 6'b100001, 6'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h78}};
        vecs[6] = '{"mixed",    24'hC09870, 6'b000000, 6'b0, 1'b0, {8'hFF, 8'hC0, 8'h90, 8'h80, 8'hF8, 8'hC0}};

        rstn           = 1'b0;
        bus.en         = 1'b1;
        bus.digits     = 24'h0;
        bus.dp_mask    = 6'h0;
        bus.blink_mask = 6'h0;
        bus.lz_en      = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset", 6'h3F, 8'hFF);
        end
        rstn       = 1'b1;
        bus.digits = 24'h123456;
        @(negedge clk);
        chk("release", 6'h3F, 8'hFF);
        run_frame("first_frame", vecs[0].exp);
        run_slot("wrap_d0", 0, 8'h82, 10);

        for (int v = 0; v < 7; v++) begin
            rearm(vecs[v].digits, vecs[v].dp, vecs[v].blink, vecs[v].lz);
            run_frame(vecs[v].name, vecs[v].exp);
        end

        // Inputs change mid-frame: rest of the frame keeps the old snapshot.
        rearm(24'h123456, 6'h0, 6'h0, 1'b0);
        run_slot("coh_old", 0, 8'h82, 10);
        run_slot("coh_old", 1, 8'h92, 10);
        run_slot("coh_old", 2, 8'h99, 10);
        bus.digits = 24'h654321;
        run_slot("coh_keep", 3, 8'hB0, 10);
        run_slot("coh_keep", 4, 8'hA4, 10);
        run_slot("coh_keep", 5, 8'hF9, 10);
        run_frame("coh_new", {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9});

        // Blink on digit 0: visible for slots 0-11, dark 12-23, visible 24-35.
        rearm(24'h000008, 6'h0, 6'b000001, 1'b0);
        for (int s = 0; s < 36; s++) begin
            int idx;
            idx = s % 6;
            if (idx == 0) run_slot("blink_d0", 0, (((s / 12) % 2) == 0) ? 8'h80 : 8'hFF, 10);
            else          run_slot("blink_other", idx, 8'hC0, 10);
        end

        // Slot 36 is in the dark phase; drop en during SHOW, then re-arm with new digits.
        run_slot("blink_dark36", 0, 8'hFF, 4);
        bus.en     = 1'b0;
        bus.digits = 24'h000009;
        @(negedge clk);
        chk("en_drop", 6'h3F, 8'hFF);
        @(negedge clk);
        chk("en_low", 6'h3F, 8'hFF);
        bus.en = 1'b1;
        @(negedge clk);
        chk("en_rearm", 6'h3F, 8'hFF);
        run_slot("rearm_visible", 0, 8'h90, 10);
        run_slot("rearm_d1", 1, 8'hC0, 10);

        // Reset asserted in the middle of a SHOW period.
        run_slot("pre_rst", 2, 8'hC0, 5);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_mid", 6'h3F, 8'hFF);
        @(negedge clk);
        chk("rst_hold", 6'h3F, 8'hFF);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_release", 6'h3F, 8'hFF);
        run_slot("post_rst", 0, 8'h90, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
